cbus_arbiter: RTL
=================

Name: cbus_arbiter

Overview:
- N-to-1 arbiter sharing the single cache-bus (cbus) port to the AXI bridge between cache masters (e.g. index 0 = dcache, index 1 = icache).
- Grants one master per burst transaction and holds the grant until the final beat.
- Steers `cbus_req_t` downstream and routes `cbus_resp_t` back only to the granted master.

Parameters:
- NUM_MASTERS, 2, number of requesting cache masters (≥2, ≤8).
- IDX_W, $clog2(NUM_MASTERS), width of the grant index (derived, not overridden).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ireqs  input  NUM_MASTERS x cbus_req_t (151 b each)  per-master cache-bus requests.
- oresps  output  NUM_MASTERS x cbus_resp_t (66 b each)  per-master responses.
- oreq  output  cbus_req_t  request to the AXI bridge.
- iresp  input  cbus_resp_t  response from the AXI bridge.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `reset`.
- State register: 2 states, IDLE and BUSY, plus a registered grant index `gnt` (IDX_W bits).
- Reset values: state=IDLE, gnt=0, round-robin pointer=0.
- While reset is high, outputs are forced combinationally: oreq='0 and every oresps[i]='0.
- IDLE:
  - oreq='0 and all oresps='0.
  - If any ireqs[i].valid, pick a winner via cbus_arb_pick, latch gnt, and go to BUSY at the next edge.
  - Arbitration latency is 1 cycle: the request is seen in cycle t, and oreq.valid first appears in t+1.
- BUSY:
  - oreq = ireqs[gnt] every cycle, passed through combinationally, so per-beat write data and strobe follow the master.
  - oresps[gnt] = iresp. All other oresps = '0 (ready=0, last=0, data=0).
  - The grant is held regardless of any other master's valid.
- Release:
  - In BUSY, the beat with iresp.ready && iresp.last returns the block to IDLE at that edge.
  - The final beat is delivered to the granted master in the same cycle.
  - There is always exactly one IDLE bubble cycle between transactions. No back-to-back grant.
- Master contract: a master holds valid and all non-data fields stable from request until its last beat.
  - If the granted master drops valid mid-burst, the arbiter stays BUSY; oreq.valid simply follows (0).
  - The arbiter does not abort.
- Simultaneous requests: resolved by the priority rule below. Losers see zero responses and keep valid asserted.
- iresp.ready while IDLE: ignored; not routed to any master.
- Reset mid-burst: the block returns to IDLE immediately. The downstream bridge is expected to be reset by the same signal.
- Combinational paths: no path from iresp to oreq.

Optional Feature:
- Macro: CBUS_ARB_RR_EN.
- Defined (round-robin):
  - Search starts at index rr_ptr and wraps modulo NUM_MASTERS.
  - On each grant, rr_ptr <= gnt+1, wrapping from NUM_MASTERS-1 back to 0.
- Undefined (fixed priority): the lowest valid index always wins, and rr_ptr logic is removed.
- The fixed-priority rule is the default build.

Decomposition:
- Shared package `common`:
  - Add `typedef enum logic {ARB_IDLE, ARB_BUSY} cbus_arb_state_t;`.
  - Existing `cbus_req_t`, `cbus_resp_t` and `mlen_t` are reused unchanged.
- Sub-module `cbus_arb_pick` (purely combinational):
  - Inputs: valid vector, start pointer.
  - Outputs: any_valid, winner index.
  - With the start pointer tied to 0 it gives fixed priority.

Test Plan:
- Single master: ireqs[1] read, len=MLEN16, valid at t0.
  - oreq.valid=1 at t1, oreq.addr=ireqs[1].addr.
  - 16 beats are routed to oresps[1] only.
  - IDLE after the beat with last=1; oresps[0] stays all-zero.
- Simultaneous requests, fixed priority (macro off): both valid at t0.
  - gnt=0, and master 0's burst completes first.
  - One IDLE cycle follows, then master 1 is granted.
- Simultaneous requests, round-robin (macro on): both held valid for 4 transactions of len=MLEN1.
  - Grant sequence is 0,1,0,1.
- Write burst: master 0 write, len=MLEN4, data changes per beat (0x11,0x22,0x33,0x44).
  - oreq.data tracks each beat in the same cycle, and strobe passes through.
- Reset mid-burst: reset asserted at beat 2 of 16.
  - The next cycle shows state IDLE, oreq.valid=0 and all oresps zero.
  - After deassertion, a new request is granted with 1-cycle latency.
- Contention during a burst: master 1 raises valid at beat 3 of master 0's MLEN8 burst.
  - The grant is not preempted.
  - Master 1 sees ready=0 until master 0's last beat plus one bubble cycle.

Source files
------------

// File: rtl/common.sv
// rtl/common.sv - shared cache-bus types: request/response structs, burst lengths, arbiter state.
package common;

  localparam int MLEN_W = 8;
  typedef logic [MLEN_W-1:0] mlen_t;

  // AXI-style encoding: beats = len + 1
  localparam mlen_t MLEN1  = 8'd0;
  localparam mlen_t MLEN2  = 8'd1;
  localparam mlen_t MLEN4  = 8'd3;
  localparam mlen_t MLEN8  = 8'd7;
  localparam mlen_t MLEN16 = 8'd15;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    mlen_t       len;
    logic [1:0]  burst;
    logic [63:0] data;
    logic [7:0]  strobe;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic {ARB_IDLE, ARB_BUSY} cbus_arb_state_t;

endpackage

// File: rtl/cbus_arb_pick.sv
// rtl/cbus_arb_pick.sv - combinational winner search starting at a rotating pointer.
module cbus_arb_pick #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] start,
  output logic             any_valid,
  output logic [IDX_W-1:0] winner
);

  always_comb begin
    int idx;
    any_valid = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(start) + i) % N;
      if (!any_valid && valid[idx[IDX_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// rtl/cbus_arbiter.sv - N-to-1 cache-bus arbiter, one grant per burst held until the last beat.
// CBUS_ARB_RR_EN selects round-robin; default build is fixed priority (lowest index wins).
module cbus_arbiter
  import common::*;
#(
  parameter  int NUM_MASTERS = 2,
  localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_MASTERS],
  output cbus_resp_t oresps [NUM_MASTERS],
  output cbus_req_t  oreq,
  input  cbus_resp_t iresp
);

  cbus_arb_state_t  state, state_next;
  logic [IDX_W-1:0] gnt, gnt_next;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] winner;
  logic             any_valid;
  logic [NUM_MASTERS-1:0] valid_vec;

`ifdef CBUS_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr, rr_next;
  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_MASTERS; i++) valid_vec[i] = ireqs[i].valid;
  end

  cbus_arb_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick (
    .valid     (valid_vec),
    .start     (start),
    .any_valid (any_valid),
    .winner    (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ARB_IDLE;
      gnt    <= '0;
`ifdef CBUS_ARB_RR_EN
      rr_ptr <= '0;
`endif
    end else begin
      state  <= state_next;
      gnt    <= gnt_next;
`ifdef CBUS_ARB_RR_EN
      rr_ptr <= rr_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    gnt_next   = gnt;
`ifdef CBUS_ARB_RR_EN
    rr_next    = rr_ptr;
`endif
    if (state == ARB_IDLE) begin
      if (any_valid) begin
        state_next = ARB_BUSY;
        gnt_next   = winner;
`ifdef CBUS_ARB_RR_EN
        rr_next    = (winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
`endif
      end
    end else if (iresp.ready && iresp.last) begin
      state_next = ARB_IDLE;
    end
  end

  // Request steering depends only on state/gnt, so iresp never reaches oreq.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_MASTERS; i++) oresps[i] = '0;
    if (!reset && state == ARB_BUSY) begin
      oreq        = ireqs[gnt];
      oresps[gnt] = iresp;
    end
  end

endmodule
